// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sequencer: walks all 2^N input vectors, holds each for HOLD
// cycles, compares the DUT output on the last cycle of each window against EXPECT.
module tt_sweep_checker #(
  parameter int N = 4,
  parameter int HOLD = 20,
  parameter logic [2**N-1:0] EXPECT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] dut_in,
  input  logic         dut_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail,
  output logic         first_fail_valid
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int NV = N + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);
  // One extra bit keeps the vector register from wrapping on the final compare.
  localparam logic [N:0] VEC_LAST = {1'b0, {N{1'b1}}};

  logic [1:0]    state_q, state_d;
  logic [N:0]    vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    err_q, err_d;
  logic [N-1:0]  ff_q, ff_d;
  logic          ffv_q, ffv_d;
  logic          sample_hit;
  logic          mismatch;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ff_d       = ff_q;
    ffv_d      = ffv_q;
    sample_hit = (state_q == S_RUN) && (cnt_q == CNT_LAST);
    mismatch   = sample_hit && (dut_out != EXPECT[vec_q[N-1:0]]);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (sample_hit) begin
          cnt_d = '0;
          if (mismatch) begin
            err_d = err_q + NV'(1);
            if (!ffv_q) begin
              ff_d  = vec_q[N-1:0];
              ffv_d = 1'b1;
            end
          end
          if (vec_q == VEC_LAST) state_d = S_DONE;
          else                   vec_d   = vec_q + NV'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
    end
  end

  // Outputs decode from registered state so an async reset clears them immediately.
  assign dut_in           = (state_q == S_RUN) ? vec_q[N-1:0] : '0;
  assign busy             = (state_q == S_RUN);
  assign done             = (state_q == S_DONE);
  assign pass             = (state_q == S_DONE) && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: three instances (N=4/HOLD=20, N=4/HOLD=1,
// N=1/HOLD=3) with behavioural DUT models and a scoreboard of expected sweep results.
module tb_tt_sweep_checker;

  localparam logic [15:0] EXP_A = 16'hA5C3;
  localparam logic [15:0] EXP_B = 16'h0000;
  localparam logic [1:0]  EXP_C = 2'b10;

  logic       clk;
  logic       rst;
  logic [2:0] start_v;
  int         mode_a;

  logic [3:0] din_a, din_b, ff_a, ff_b;
  logic [0:0] din_c, ff_c;
  logic [4:0] err_a, err_b;
  logic [1:0] err_c;
  logic       dout_a, dout_b, dout_c;
  logic [2:0] busy_w, done_w, pass_w, ffv_w;
  logic [7:0] din_w [3];
  logic [8:0] err_w [3];
  logic [7:0] ff_w  [3];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int   err;
    int   ff;
    logic ffv;
    logic pass;
  } exp_t;
  exp_t sb[$];

  tt_sweep_checker #(.N(4), .HOLD(20), .EXPECT(EXP_A)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .dut_in(din_a), .dut_out(dout_a),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_a),
    .first_fail(ff_a), .first_fail_valid(ffv_w[0]));

  tt_sweep_checker #(.N(4), .HOLD(1), .EXPECT(EXP_B)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .dut_in(din_b), .dut_out(dout_b),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_b),
    .first_fail(ff_b), .first_fail_valid(ffv_w[1]));

  tt_sweep_checker #(.N(1), .HOLD(3), .EXPECT(EXP_C)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .dut_in(din_c), .dut_out(dout_c),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err_c),
    .first_fail(ff_c), .first_fail_valid(ffv_w[2]));

  // Behavioural lab blocks: A matches EXPECT (mode 0) or is stuck at 0 (mode 1),
  // B is high only on vector 9, C is a pass-through of its single input.
  assign dout_a = (mode_a == 0) ? EXP_A[din_a] : 1'b0;
  assign dout_b = (din_b == 4'd9);
  assign dout_c = din_c[0];

  assign din_w[0] = {4'b0, din_a};
  assign din_w[1] = {4'b0, din_b};
  assign din_w[2] = {7'b0, din_c};
  assign err_w[0] = {4'b0, err_a};
  assign err_w[1] = {4'b0, err_b};
  assign err_w[2] = {7'b0, err_c};
  assign ff_w[0]  = {4'b0, ff_a};
  assign ff_w[1]  = {4'b0, ff_b};
  assign ff_w[2]  = {7'b0, ff_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected sweep outcome, derived from the DUT models and truth tables above.
  function automatic exp_t predict(input int u, input int mode);
    exp_t e;
    int   nvec;
    logic m, x;
    e.err = 0; e.ff = 0; e.ffv = 1'b0;
    nvec = (u == 2) ? 2 : 16;
    for (int v = 0; v < nvec; v++) begin
      case (u)
        0:       begin m = (mode == 0) ? EXP_A[v] : 1'b0; x = EXP_A[v]; end
        1:       begin m = (v == 9);                      x = EXP_B[v]; end
        default: begin m = v[0];                          x = EXP_C[v]; end
      endcase
      if (m != x) begin
        e.err++;
        if (!e.ffv) begin e.ff = v; e.ffv = 1'b1; end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic check_idle(input int u, input string tag);
    check({tag, "_busy"}, 32'(busy_w[u]), 0);
    check({tag, "_done"}, 32'(done_w[u]), 0);
    check({tag, "_pass"}, 32'(pass_w[u]), 0);
    check({tag, "_err"},  32'(err_w[u]),  0);
    check({tag, "_ff"},   32'(ff_w[u]),   0);
    check({tag, "_ffv"},  32'(ffv_w[u]),  0);
    check({tag, "_din"},  32'(din_w[u]),  0);
  endtask

  task automatic kick(input int u);
    @(negedge clk);
    start_v[u] = 1'b1;
    @(negedge clk);
    start_v[u] = 1'b0;
  endtask

  // Called at the first negedge after the accepted start edge.
  task automatic wait_done(input int u, input int hold, input int nvec, input string tag);
    int   j;
    exp_t e;
    j = 0;
    while (busy_w[u] === 1'b1 && j < nvec * hold + 8) begin
      check({tag, "_din_step"}, 32'(din_w[u]), 32'(j / hold));
      j++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(j), 32'(nvec * hold));
    check({tag, "_done"}, 32'(done_w[u]), 1);
    check({tag, "_din_done"}, 32'(din_w[u]), 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_err"},  32'(err_w[u]), 32'(e.err));
      check({tag, "_ff"},   32'(ff_w[u]),  32'(e.ff));
      check({tag, "_ffv"},  32'(ffv_w[u]), 32'(e.ffv));
      check({tag, "_pass"}, 32'(pass_w[u]), 32'(e.pass));
      $display("sweep %s: err=%0d first_fail=%0d valid=%0b pass=%0b busy=%0d",
               tag, err_w[u], ff_w[u], ffv_w[u], pass_w[u], j);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start_v = 3'b000;
    mode_a  = 0;
    #12;
    for (int u = 0; u < 3; u++) check_idle(u, "reset");
    @(negedge clk);
    rst = 1'b0;

    // Matching DUT, then stuck-at-0 DUT on the 4-input, 20-cycle instance.
    mode_a = 0;
    sb.push_back(predict(0, 0));
    kick(0);
    wait_done(0, 20, 16, "a_match");

    mode_a = 1;
    sb.push_back(predict(0, 1));
    kick(0);
    wait_done(0, 20, 16, "a_stuck0");

    sb.push_back(predict(1, 0));
    kick(1);
    wait_done(1, 1, 16, "b_hold1");

    sb.push_back(predict(2, 0));
    kick(2);
    wait_done(2, 3, 2, "c_n1");

    // start held through RUN and the DONE-entry edge; the following edge restarts.
    @(negedge clk);
    mode_a     = 1;
    start_v[0] = 1'b1;
    sb.push_back(predict(0, 1));
    @(negedge clk);
    wait_done(0, 20, 16, "a_held");
    @(negedge clk);
    check("restart_busy", 32'(busy_w[0]), 1);
    check("restart_done", 32'(done_w[0]), 0);
    check("restart_pass", 32'(pass_w[0]), 0);
    check("restart_err",  32'(err_w[0]),  0);
    check("restart_ffv",  32'(ffv_w[0]),  0);
    check("restart_ff",   32'(ff_w[0]),   0);
    start_v[0] = 1'b0;
    mode_a     = 0;
    sb.push_back(predict(0, 0));
    wait_done(0, 20, 16, "a_restart");

    // Asynchronous reset 100 cycles into a failing sweep.
    mode_a = 1;
    kick(0);
    repeat (99) @(negedge clk);
    check("pre_rst_busy", 32'(busy_w[0]), 1);
    check("pre_rst_err_nonzero", 32'(err_w[0] != 0), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle(0, "async_rst");
    #3 rst = 1'b0;
    repeat (30) @(negedge clk);
    check_idle(0, "post_rst");
    $display("async reset: busy=%0b done=%0b err=%0d", busy_w[0], done_w[0], err_w[0]);

    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
